alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle command sequencer placed directly upstream of the combinational ALU. It accepts one operation per valid/ready handshake, drives the ALU's OP/A/B inputs from registers and captures R. Multi-bit shifts are built by iterating the ALU's 1-bit shift. It holds the result, with zero and illegal flags, until the writeback stage consumes it.

## Interface
- BIT_WIDTH, 32, datapath width; must match the ALU's bit_width
- SHAMT_W, $clog2(BIT_WIDTH), shift-amount field width taken from in_b

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  command present
- in_ready  out  1  sequencer can accept a command
- in_op  in  4  ALU opcode: ADD=0, SUB=1, NOT=2, AND=3, OR=4, XOR=5, RSH=6, LSH=7, CMP_GREATER=8, CMP_EQUAL=9, CMP_LESS=10
- in_a  in  BIT_WIDTH  operand A
- in_b  in  BIT_WIDTH  operand B; for shifts, bits [SHAMT_W-1:0] are the shift amount
- alu_op  out  4  to ALU OP
- alu_a  out  BIT_WIDTH  to ALU A
- alu_b  out  BIT_WIDTH  to ALU B
- alu_r  in  BIT_WIDTH  from ALU R, combinational
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_result  out  BIT_WIDTH  registered result
- out_zero  out  1  out_result == 0, registered with the result
- out_illegal  out  1  opcode 11..15 was received

## Operation
- States: IDLE, EXEC, SHIFT, DONE.
- in_ready = (state == IDLE). A command is accepted when in_valid && in_ready at a rising edge. Accepting latches op, a and b; a is also latched into the accumulator.
- Transitions out of IDLE on accept:
  - op > 10: go to DONE with result = 0 and illegal = 1. The ALU is not used.
  - op 6/7 with shift amount 0: go to DONE with result = a.
  - op 6/7 with amount n > 0: load count = n and go to SHIFT.
  - Any other op: go to EXEC.
- EXEC: drive alu_op = op, alu_a = a, alu_b = b. At the next edge capture alu_r into result and go to DONE.
- SHIFT: drive alu_op = op and alu_a = accumulator. At each edge load the accumulator from alu_r and decrement count. When count == 1 at the edge, also load the result and go to DONE.
- DONE: out_valid = 1, with result, zero and illegal held stable. On out_ready, go to IDLE and clear out_valid. in_ready rises in the same cycle as the IDLE return.
- alu_op/alu_a/alu_b are registered. They are 0 outside EXEC/SHIFT.
- Arithmetic is modulo 2^BIT_WIDTH and the carry is discarded. SUB result = a − b. Comparisons return all-ones or all-zeros.
- Shift amounts ≥ BIT_WIDTH are impossible by field width. An amount of BIT_WIDTH−1 is the maximum.

## Timing
- Latency is counted from the accepting edge to out_valid high:
  - EXEC ops: 2 edges.
  - Shift with n ≥ 1: 1 + n edges.
  - Shift with n = 0: 1 edge.
  - Illegal op: 1 edge.
- Throughput: one command per (latency + 1) cycles minimum. There is no overlap: in_ready stays low from the accept until the DONE handshake.
- out_valid stays high indefinitely while out_ready = 0, and the outputs do not change.
- in_valid while busy is ignored. Upstream must hold its command.
- Reset values:
  - out_valid 0, out_result 0, out_zero 0, out_illegal 0.
  - alu_op 0, alu_a 0, alu_b 0.
  - in_ready is 1 once state = IDLE.
- Reset asserted mid-operation aborts the command with no result. The state returns to IDLE immediately, asynchronously.

## Configuration
- ALU_SEQ_MULTISHIFT_EN defined:
  - Multi-bit shifts are iterated as described above.
- Not defined:
  - RSH/LSH take the EXEC path and shift by exactly 1, with b ignored.
  - The SHIFT state and counter are not built.
  - Shift latency is 2 edges.

## Test plan
- Reset: with rst pulsed, all outputs return to the reset values and in_ready = 1.
- Arithmetic: ADD a=0xFFFFFFFF, b=1 gives result 0 and zero = 1 after 2 edges. SUB a=5, b=7 gives 0xFFFFFFFE and zero = 0.
- Multi-shift (macro defined): LSH a=0x1, b=5 gives 0x20 after 6 edges. RSH a=0x80000000, b=31 gives 0x1. RSH b=0 gives a unchanged after 1 edge.
- Illegal opcode: op=12 gives result 0 and illegal = 1 after 1 edge. alu_op stays 0 throughout.
- Backpressure: CMP_LESS a=3, b=9 with out_ready = 0 for 10 cycles. The bench requires:
  - result 0xFFFFFFFF held stable for all 10 cycles;
  - in_ready = 0 for that duration;
  - in_ready = 1 in the cycle after out_ready rises.
- Reset mid-shift: LSH b=20 with rst asserted after 5 edges. out_valid never rises, and the next ADD 2+2 returns 4.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle command sequencer feeding a combinational ALU.
// Accepts one command per valid/ready handshake, drives the ALU operands from
// registers, captures the ALU result and holds it until writeback takes it.
// Optional feature macro: ALU_SEQ_MULTISHIFT_EN builds iterated multi-bit
// shifts (SHIFT state plus shift counter). Without it, RSH/LSH shift by one
// through the normal EXEC path.
module alu_sequencer #(
    parameter int BIT_WIDTH = 32,
    parameter int SHAMT_W   = $clog2(BIT_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_op,
    input  logic [BIT_WIDTH-1:0] in_a,
    input  logic [BIT_WIDTH-1:0] in_b,
    output logic [3:0]           alu_op,
    output logic [BIT_WIDTH-1:0] alu_a,
    output logic [BIT_WIDTH-1:0] alu_b,
    input  logic [BIT_WIDTH-1:0] alu_r,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_result,
    output logic                 out_zero,
    output logic                 out_illegal
);

    localparam logic [3:0] OP_RSH = 4'd6;
    localparam logic [3:0] OP_LSH = 4'd7;
    localparam logic [3:0] OP_MAX = 4'd10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic accept;
    logic is_illegal;

    assign accept     = in_valid && (state == IDLE);
    assign is_illegal = (in_op > OP_MAX);

`ifdef ALU_SEQ_MULTISHIFT_EN
    logic               is_shift;
    logic [SHAMT_W-1:0] shamt;
    logic [SHAMT_W-1:0] count;

    assign is_shift = (in_op == OP_RSH) || (in_op == OP_LSH);
    assign shamt    = in_b[SHAMT_W-1:0];
`endif

    // State register; reset aborts any command in flight immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_illegal) begin
                        state_next = DONE;
`ifdef ALU_SEQ_MULTISHIFT_EN
                    end else if (is_shift && (shamt == '0)) begin
                        state_next = DONE;
                    end else if (is_shift) begin
                        state_next = SHIFT;
`endif
                    end else begin
                        state_next = EXEC;
                    end
                end
            end
            EXEC: begin
                state_next = DONE;
            end
`ifdef ALU_SEQ_MULTISHIFT_EN
            SHIFT: begin
                if (count == SHAMT_W'(1)) begin
                    state_next = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath: ALU operand registers (alu_a doubles as the shift accumulator),
    // shift counter and the held result with its flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_op      <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            out_result  <= '0;
            out_zero    <= 1'b0;
            out_illegal <= 1'b0;
`ifdef ALU_SEQ_MULTISHIFT_EN
            count       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_illegal) begin
                            // The ALU is bypassed entirely for bad opcodes
                            out_result  <= '0;
                            out_zero    <= 1'b1;
                            out_illegal <= 1'b1;
`ifdef ALU_SEQ_MULTISHIFT_EN
                        end else if (is_shift && (shamt == '0)) begin
                            out_result  <= in_a;
                            out_zero    <= (in_a == '0);
                            out_illegal <= 1'b0;
`endif
                        end else begin
                            alu_op <= in_op;
                            alu_a  <= in_a;
                            alu_b  <= in_b;
`ifdef ALU_SEQ_MULTISHIFT_EN
                            count  <= shamt;
`endif
                        end
                    end
                end
                EXEC: begin
                    out_result  <= alu_r;
                    out_zero    <= (alu_r == '0);
                    out_illegal <= 1'b0;
                    alu_op      <= '0;
                    alu_a       <= '0;
                    alu_b       <= '0;
                end
`ifdef ALU_SEQ_MULTISHIFT_EN
                SHIFT: begin
                    count <= count - SHAMT_W'(1);
                    if (count == SHAMT_W'(1)) begin
                        out_result  <= alu_r;
                        out_zero    <= (alu_r == '0);
                        out_illegal <= 1'b0;
                        alu_op      <= '0;
                        alu_a       <= '0;
                        alu_b       <= '0;
                    end else begin
                        alu_a <= alu_r;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer with a behavioural ALU attached.
module tb_alu_sequencer;

    localparam int W = 32;

`ifdef ALU_SEQ_MULTISHIFT_EN
    localparam bit MULTI = 1'b1;
`else
    localparam bit MULTI = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [3:0]   alu_op;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_r;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_zero;
    logic         out_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    alu_sequencer #(.BIT_WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_r      (alu_r),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural combinational ALU
    always_comb begin
        case (alu_op)
            4'd0:    alu_r = alu_a + alu_b;
            4'd1:    alu_r = alu_a - alu_b;
            4'd2:    alu_r = ~alu_a;
            4'd3:    alu_r = alu_a & alu_b;
            4'd4:    alu_r = alu_a | alu_b;
            4'd5:    alu_r = alu_a ^ alu_b;
            4'd6:    alu_r = alu_a >> 1;
            4'd7:    alu_r = alu_a << 1;
            4'd8:    alu_r = (alu_a > alu_b)  ? '1 : '0;
            4'd9:    alu_r = (alu_a == alu_b) ? '1 : '0;
            4'd10:   alu_r = (alu_a < alu_b)  ? '1 : '0;
            default: alu_r = '0;
        endcase
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a command, wait for acceptance and count edges until out_valid
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat);
        int t;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drain_in_ready", {31'd0, in_ready}, 32'd1);
        check("drain_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_r, input logic exp_z,
                         input logic exp_ill, input int exp_lat);
        int lat;
        issue(op, a, b, lat);
        check({tag, "_latency"}, W'(lat), W'(exp_lat));
        check({tag, "_result"}, out_result, exp_r);
        check({tag, "_zero"}, {31'd0, out_zero}, {31'd0, exp_z});
        check({tag, "_illegal"}, {31'd0, out_illegal}, {31'd0, exp_ill});
        check({tag, "_alu_op_idle"}, {28'd0, alu_op}, 32'd0);
        drain();
    endtask

    initial begin
        int lat;
        bit seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_zero", {31'd0, out_zero}, 32'd0);
        check("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
        check("rst_alu_op", {28'd0, alu_op}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Arithmetic and logic
        do_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 2);
        do_op("sub_neg", 4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 2);
        do_op("xor", 4'd5, 32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000, 1'b0, 1'b0, 2);
        do_op("not", 4'd2, 32'hFFFF_0000, 32'd0, 32'h0000_FFFF, 1'b0, 1'b0, 2);
        do_op("cmp_eq", 4'd9, 32'd42, 32'd42, 32'hFFFF_FFFF, 1'b0, 1'b0, 2);

        // Shifts
        if (MULTI) begin
            do_op("lsh5", 4'd7, 32'h1, 32'd5, 32'h20, 1'b0, 1'b0, 6);
            do_op("rsh31", 4'd6, 32'h8000_0000, 32'd31, 32'h1, 1'b0, 1'b0, 32);
            do_op("rsh0", 4'd6, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0, 1'b0, 1);
        end else begin
            do_op("lsh5", 4'd7, 32'h1, 32'd5, 32'h2, 1'b0, 1'b0, 2);
            do_op("rsh31", 4'd6, 32'h8000_0000, 32'd31, 32'h4000_0000, 1'b0, 1'b0, 2);
            do_op("rsh0", 4'd6, 32'h1234_5678, 32'd0, 32'h091A_2B3C, 1'b0, 1'b0, 2);
        end

        // Illegal opcode
        do_op("illegal12", 4'd12, 32'h55, 32'h66, 32'd0, 1'b1, 1'b1, 1);

        // Backpressure
        issue(4'd10, 32'd3, 32'd9, lat);
        check("bp_latency", W'(lat), 32'd2);
        for (int i = 0; i < 10; i++) begin
            check("bp_result", out_result, 32'hFFFF_FFFF);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            @(posedge clk); #1;
        end
        drain();

        // Reset in the middle of a long shift
        in_op    = 4'd7;
        in_a     = 32'h1;
        in_b     = 32'd20;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (MULTI) begin
            repeat (4) begin
                @(posedge clk); #1;
            end
        end
        check("midrst_busy", {31'd0, in_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_alu_a", alu_a, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_valid", {31'd0, seen}, 32'd0);
        do_op("add_after_rst", 4'd0, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
